if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/riscv_pkg.sv | 14 +
 rtl/if_id_reg.sv | 36 +++
 rtl/if_stage.sv | 77 +++++++
 tb/tb_if_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: priority flush (bubble) > hold > load.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            hold,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc_plus4D,
  output logic [XLEN-1:0] instrD,
  output logic            validD
);

  // A bubble keeps the PC fields and only replaces the instruction with a NOP.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pcD       <= '0;
      pc_plus4D <= '0;
      instrD    <= NOP;
      validD    <= 1'b0;
    end else if (flush) begin
      instrD    <= NOP;
      validD    <= 1'b0;
    end else if (!hold) begin
      pcD       <= pc_in;
      pc_plus4D <= pc_plus4_in;
      instrD    <= instr_in;
      validD    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection, FETCH/HALT control
// and the IF/ID register feeding decode.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stallF,
  input  logic            flushD,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc_plus4D,
  output logic [XLEN-1:0] instrD,
  output logic            validD,
  output logic            halted,
  output logic            misalign_err
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            advance;
  logic            ifid_flush;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // PC moves forward only in FETCH with no stall and no redirect.
  assign advance    = (state == FETCH) && !redirect_valid && !stallF;
  // Decode sees a bubble on redirect, explicit flush, or while halted.
  assign ifid_flush = redirect_valid || flushD || (state == HALT);

  // PC register and FETCH/HALT state; halt only when EBREAK actually lands in IF/ID.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc           <= RESET_PC;
      state        <= FETCH;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (redirect_valid) begin
        pc           <= {redirect_pc[XLEN-1:2], 2'b00};
        state        <= FETCH;
        halted       <= 1'b0;
        misalign_err <= |redirect_pc[1:0];
      end else if (advance) begin
        pc <= pc_plus4;
        if (!flushD && (imem_rdata == EBREAK)) begin
          state  <= HALT;
          halted <= 1'b1;
        end
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (ifid_flush),
    .hold        (stallF),
    .pc_in       (pc),
    .pc_plus4_in (pc_plus4),
    .instr_in    (imem_rdata),
    .pcD         (pcD),
    .pc_plus4D   (pc_plus4D),
    .instrD      (instrD),
    .validD      (validD)
  );

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model.
module tb_if_stage;

  localparam logic [31:0] NOP_W    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_W = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stallF = 1'b0;
  logic        flushD = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pcD, pc_plus4D, instrD;
  logic        validD, halted, misalign_err;

  logic [31:0] ram [64];

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  logic [31:0] m_pc, m_pcd, m_pc4, m_ins;
  logic        m_v, m_halt, m_mis;

  always #5 clk = ~clk;

  assign imem_rdata = ram[imem_addr[7:2]];

  if_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .stallF         (stallF),
    .flushD         (flushD),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .pcD            (pcD),
    .pc_plus4D      (pc_plus4D),
    .instrD         (instrD),
    .validD         (validD),
    .halted         (halted),
    .misalign_err   (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the fetch rules for one clock edge, using the inputs as they stand.
  task automatic model_edge();
    logic [31:0] word;
    word = ram[m_pc[7:2]];
    if (!rstn) begin
      m_pc = 32'h0; m_halt = 1'b0; m_pcd = 32'h0; m_pc4 = 32'h0;
      m_ins = NOP_W; m_v = 1'b0; m_mis = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (redirect_valid) begin
        m_pc   = redirect_pc & 32'hFFFF_FFFC;
        m_halt = 1'b0;
        m_mis  = (redirect_pc % 4) != 0;
        m_ins  = NOP_W; m_v = 1'b0;
      end else if (m_halt) begin
        m_ins = NOP_W; m_v = 1'b0;
      end else if (stallF) begin
        if (flushD) begin m_ins = NOP_W; m_v = 1'b0; end
      end else begin
        if (flushD) begin
          m_ins = NOP_W; m_v = 1'b0;
        end else begin
          m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_ins = word; m_v = 1'b1;
          if (word == EBREAK_W) m_halt = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cmp_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("pcD", pcD, m_pcd);
    chk("pc_plus4D", pc_plus4D, m_pc4);
    chk("instrD", instrD, m_ins);
    chk("validD", {31'b0, validD}, {31'b0, m_v});
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_all();
  endtask

  initial begin
    m_pc = 32'h0; m_pcd = 32'h0; m_pc4 = 32'h0; m_ins = NOP_W;
    m_v = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
    for (int i = 0; i < 64; i++) ram[i] = {i[11:0], 5'd0, 3'b000, 5'd1, 7'h13};
    ram[18] = EBREAK_W;

    // reset
    step(); step();
    chk("rst_instrD", instrD, NOP_W);
    chk("rst_validD", {31'b0, validD}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    // straight-line fetch
    rstn = 1'b1;
    step();
    chk("e1_pcD", pcD, 32'h0);
    chk("e1_instrD", instrD, ram[0]);
    chk("e1_validD", {31'b0, validD}, 32'h1);
    chk("e1_addr", imem_addr, 32'h4);
    step();
    chk("e2_addr", imem_addr, 32'h8);

    // stall three cycles at PC=0x8
    stallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_pcD", pcD, 32'h4);
    end
    stallF = 1'b0;
    step();
    chk("unstall_addr", imem_addr, 32'hC);

    // redirect wins over stall
    stallF = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_validD", {31'b0, validD}, 32'h0);
    chk("redir_instrD", instrD, NOP_W);
    stallF = 1'b0; redirect_valid = 1'b0;
    step();
    chk("redir_pcD", pcD, 32'h40);

    // misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    chk("mis_addr", imem_addr, 32'h40);
    chk("mis_pulse", {31'b0, misalign_err}, 32'h1);
    redirect_valid = 1'b0;
    step();
    chk("mis_clear", {31'b0, misalign_err}, 32'h0);
    step();

    // EBREAK at 0x48 latched, then halt
    step();
    chk("ebk_instrD", instrD, EBREAK_W);
    chk("ebk_validD", {31'b0, validD}, 32'h1);
    chk("ebk_pcD", pcD, 32'h48);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_flag", {31'b0, halted}, 32'h1);
      chk("halt_addr", imem_addr, 32'h4C);
      chk("halt_validD", {31'b0, validD}, 32'h0);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    chk("unhalt_flag", {31'b0, halted}, 32'h0);
    chk("unhalt_addr", imem_addr, 32'h0);

    // halt again, then reset with flush asserted
    redirect_pc = 32'h48;
    step();
    redirect_valid = 1'b0;
    step();
    chk("halt2_flag", {31'b0, halted}, 32'h1);
    rstn = 1'b0; flushD = 1'b1;
    step();
    chk("rst2_addr", imem_addr, 32'h0);
    chk("rst2_pcD", pcD, 32'h0);
    chk("rst2_pc4D", pc_plus4D, 32'h0);
    chk("rst2_instrD", instrD, NOP_W);
    chk("rst2_validD", {31'b0, validD}, 32'h0);
    chk("rst2_halted", {31'b0, halted}, 32'h0);
    chk("rst2_mis", {31'b0, misalign_err}, 32'h0);
    rstn = 1'b1; flushD = 1'b0;

    // PC wraps at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pcD", pcD, 32'hFFFF_FFFC);
    chk("wrap_pc4D", pc_plus4D, 32'h0);

    // randomized traffic
    for (int i = 0; i < 64; i++)
      ram[i] = ($urandom_range(0, 7) == 0) ? EBREAK_W : $urandom;
    for (int n = 0; n < 3000; n++) begin
      rstn           = ($urandom_range(0, 49) != 0);
      stallF         = ($urandom_range(0, 3) == 0);
      flushD         = ($urandom_range(0, 6) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 255));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
